mod_signal_monitor: RTL and testbench
=====================================

MOD_SIGNAL_MONITOR -- requirements
Module: mod_signal_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of all measurement counters and result fields.
REQ-002 SHALL have port USER_CLOCK, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port RESET, input, 1 bit, an asynchronous active-high reset.
REQ-004 SHALL have port MOD_CLK, input, 1 bit, the returned CLK modulation signal, asynchronous to USER_CLOCK.
REQ-005 SHALL have port MOD_CLKN, input, 1 bit, the returned CLKN modulation signal, asynchronous to USER_CLOCK.
REQ-006 SHALL have port MOD_CLKL, input, 1 bit, the returned CLKL (light source) signal, asynchronous to USER_CLOCK.
REQ-007 SHALL have port START, input, 1 bit, a one-cycle pulse that requests one measurement.
REQ-008 SHALL have port RESULT_ACK, input, 1 bit, which acknowledges and releases the current result.
REQ-009 SHALL have port BUSY, output, 1 bit, high in the ARM and MEAS states.
REQ-010 SHALL have port RESULT_VALID, output, 1 bit, high in the DONE state.
REQ-011 SHALL have port PERIOD, output, CNT_W bits, the CLK period in USER_CLOCK cycles.
REQ-012 SHALL have port HIGH_CLK, output, CNT_W bits, the number of cycles CLK is high within one period.
REQ-013 SHALL have port HIGH_CLKN, output, CNT_W bits, the number of cycles CLKN is high within one period.
REQ-014 SHALL have port PHASE, output, CNT_W bits, the delay from the CLK rise to the CLKL rise.
REQ-015 SHALL have port OVERLAP, output, CNT_W bits, the number of cycles in which CLK and CLKN are both high.
REQ-016 SHALL have port PHASE_MISS, output, 1 bit, set when no CLKL rise occurred in the window.
REQ-017 SHALL have port TIMEOUT, output, 1 bit, set when the measurement was aborted.

Function
REQ-018 SHALL pass each MOD_* input through a 2-flop synchronizer followed by a 1-flop edge-detect stage; a pin edge SHALL produce a rise strobe 3 cycles later.
REQ-019 SHALL implement the states IDLE, ARM, MEAS and DONE.
REQ-020 SHALL, in IDLE, move to ARM on START, clearing all counters and flags.
REQ-021 SHALL, in ARM, move to MEAS on the synchronized CLK rise strobe (rise1).
REQ-022 SHALL, in ARM, increment a wait counter each cycle; when it reaches 2^CNT_W-1, SHALL set TIMEOUT, set all result fields to all-ones, and move to DONE.
REQ-023 SHALL define the window as the cycles from rise1 up to, but excluding, the next CLK rise strobe (rise2); on rise2 the state SHALL move to DONE.
REQ-024 SHALL set PERIOD to the number of cycles in the window.
REQ-025 SHALL set HIGH_CLK, HIGH_CLKN and OVERLAP to the counts of window cycles in which, respectively, sync CLK=1, sync CLKN=1, and both are 1.
REQ-026 SHALL set PHASE to (cycle index of the first CLKL rise strobe) minus (cycle index of rise1), so a coincident rise gives 0; with no CLKL rise in the window, PHASE SHALL be all-ones and PHASE_MISS SHALL be 1.
REQ-027 SHALL abort to DONE with TIMEOUT=1 if the window counter reaches 2^CNT_W-1 in MEAS; partially accumulated fields SHALL be retained, and PERIOD SHALL equal 2^CNT_W-1.
REQ-028 SHALL register result fields on entry to DONE and hold them stable until the next START is accepted.
REQ-029 SHALL, in DONE, return to IDLE on RESULT_ACK alone, with RESULT_VALID falling in the following cycle.
REQ-030 SHALL, in DONE, re-enter ARM on START; when START and RESULT_ACK coincide, START SHALL win.
REQ-031 SHALL ignore START in ARM and MEAS.

Reset
REQ-032 SHALL, on RESET, immediately force IDLE and drive BUSY, RESULT_VALID, PHASE_MISS and TIMEOUT to 0 and all result fields to 0.
REQ-033 SHALL clear the synchronizer flops on RESET.
REQ-034 SHALL, after a mid-measurement RESET, require a new START before any result is produced.

Verification
REQ-035 SHALL cover: CLK period 40, high 20; CLKN inverted; CLKL delayed 10 -> PERIOD=40, HIGH_CLK=20, HIGH_CLKN=20, PHASE=10, OVERLAP=0, PHASE_MISS=0.
REQ-036 SHALL cover: same signals but CLKN rises 2 cycles before CLK falls -> HIGH_CLKN=22, OVERLAP=2.
REQ-037 SHALL cover: CNT_W=8 with CLK stuck low -> TIMEOUT=1 and RESULT_VALID 255 cycles after START plus one state-transition cycle; results all-ones.
REQ-038 SHALL cover: CLKL held low -> PHASE=all-ones, PHASE_MISS=1, other fields correct.
REQ-039 SHALL cover: RESET asserted in MEAS -> BUSY=0 and RESULT_VALID=0 immediately, no result until a new START.
REQ-040 SHALL cover: START and RESULT_ACK asserted together in DONE -> state ARM, RESULT_VALID=0 next cycle, BUSY=1.

Source files
------------

// File: rtl/mod_signal_monitor.sv
// Measures one period of the returned CLK/CLKN/CLKL modulation signals: period, high times,
// CLK/CLKN overlap and CLK->CLKL phase, all in USER_CLOCK cycles.
module mod_signal_monitor #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             USER_CLOCK,
    input  logic             RESET,
    input  logic             MOD_CLK,
    input  logic             MOD_CLKN,
    input  logic             MOD_CLKL,
    input  logic             START,
    input  logic             RESULT_ACK,
    output logic             BUSY,
    output logic             RESULT_VALID,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_CLK,
    output logic [CNT_W-1:0] HIGH_CLKN,
    output logic [CNT_W-1:0] PHASE,
    output logic [CNT_W-1:0] OVERLAP,
    output logic             PHASE_MISS,
    output logic             TIMEOUT
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

    typedef enum logic [1:0] {StIdle, StArm, StMeas, StDone} state_e;

    // Bit 0 = CLK, bit 1 = CLKN, bit 2 = CLKL. lvl and rise change on the same edge.
    logic [2:0] pin, sync1, sync2, lvl, rise;

    assign pin = {MOD_CLKL, MOD_CLKN, MOD_CLK};

    always_ff @(posedge USER_CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            rise  <= '0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            lvl   <= sync2;
            rise  <= sync2 & ~lvl;
        end
    end

    state_e           state_q;
    logic [CNT_W-1:0] wait_cnt, period_cnt, hi_clk_cnt, hi_clkn_cnt, ovl_cnt, phase_cnt;
    logic             phase_seen;
    logic [CNT_W-1:0] win_period, win_hi_clk, win_hi_clkn, win_ovl, win_phase;
    logic             win_seen;
    logic             accept;

    // Accumulators advanced by the current window cycle.
    always_comb begin
        win_period  = period_cnt + CNT_ONE;
        win_hi_clk  = hi_clk_cnt + (lvl[0] ? CNT_ONE : '0);
        win_hi_clkn = hi_clkn_cnt + (lvl[1] ? CNT_ONE : '0);
        win_ovl     = ovl_cnt + ((lvl[0] && lvl[1]) ? CNT_ONE : '0);
        win_phase   = phase_cnt;
        win_seen    = phase_seen;
        if (rise[2] && !phase_seen) begin
            win_phase = period_cnt;
            win_seen  = 1'b1;
        end
    end

    assign accept = START && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge USER_CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            BUSY         <= 1'b0;
            RESULT_VALID <= 1'b0;
            PHASE_MISS   <= 1'b0;
            TIMEOUT      <= 1'b0;
            PERIOD       <= '0;
            HIGH_CLK     <= '0;
            HIGH_CLKN    <= '0;
            PHASE        <= '0;
            OVERLAP      <= '0;
            wait_cnt     <= '0;
            period_cnt   <= '0;
            hi_clk_cnt   <= '0;
            hi_clkn_cnt  <= '0;
            ovl_cnt      <= '0;
            phase_cnt    <= '0;
            phase_seen   <= 1'b0;
        end else if (accept) begin
            state_q      <= StArm;
            BUSY         <= 1'b1;
            RESULT_VALID <= 1'b0;
            PHASE_MISS   <= 1'b0;
            TIMEOUT      <= 1'b0;
            PERIOD       <= '0;
            HIGH_CLK     <= '0;
            HIGH_CLKN    <= '0;
            PHASE        <= '0;
            OVERLAP      <= '0;
            wait_cnt     <= '0;
            period_cnt   <= '0;
            hi_clk_cnt   <= '0;
            hi_clkn_cnt  <= '0;
            ovl_cnt      <= '0;
            phase_cnt    <= '0;
            phase_seen   <= 1'b0;
        end else begin
            case (state_q)
                StArm: begin
                    // The rise1 cycle is the first window cycle.
                    if (rise[0]) begin
                        state_q     <= StMeas;
                        period_cnt  <= win_period;
                        hi_clk_cnt  <= win_hi_clk;
                        hi_clkn_cnt <= win_hi_clkn;
                        ovl_cnt     <= win_ovl;
                        phase_cnt   <= win_phase;
                        phase_seen  <= win_seen;
                    end else if (wait_cnt == CNT_LAST) begin
                        state_q      <= StDone;
                        BUSY         <= 1'b0;
                        RESULT_VALID <= 1'b1;
                        TIMEOUT      <= 1'b1;
                        PHASE_MISS   <= 1'b1;
                        PERIOD       <= CNT_MAX;
                        HIGH_CLK     <= CNT_MAX;
                        HIGH_CLKN    <= CNT_MAX;
                        PHASE        <= CNT_MAX;
                        OVERLAP      <= CNT_MAX;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                StMeas: begin
                    if (rise[0]) begin
                        state_q      <= StDone;
                        BUSY         <= 1'b0;
                        RESULT_VALID <= 1'b1;
                        PERIOD       <= period_cnt;
                        HIGH_CLK     <= hi_clk_cnt;
                        HIGH_CLKN    <= hi_clkn_cnt;
                        OVERLAP      <= ovl_cnt;
                        PHASE        <= phase_seen ? phase_cnt : CNT_MAX;
                        PHASE_MISS   <= !phase_seen;
                    end else if (win_period == CNT_MAX) begin
                        state_q      <= StDone;
                        BUSY         <= 1'b0;
                        RESULT_VALID <= 1'b1;
                        TIMEOUT      <= 1'b1;
                        PERIOD       <= CNT_MAX;
                        HIGH_CLK     <= win_hi_clk;
                        HIGH_CLKN    <= win_hi_clkn;
                        OVERLAP      <= win_ovl;
                        PHASE        <= win_seen ? win_phase : CNT_MAX;
                        PHASE_MISS   <= !win_seen;
                    end else begin
                        period_cnt  <= win_period;
                        hi_clk_cnt  <= win_hi_clk;
                        hi_clkn_cnt <= win_hi_clkn;
                        ovl_cnt     <= win_ovl;
                        phase_cnt   <= win_phase;
                        phase_seen  <= win_seen;
                    end
                end
                StDone: begin
                    if (RESULT_ACK) begin
                        state_q      <= StIdle;
                        RESULT_VALID <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_signal_monitor.sv
// Self-checking bench for mod_signal_monitor (CNT_W = 8): directed table, corner sequences
// and randomized periodic waveforms checked against a waveform-counting model.
module tb_mod_signal_monitor;

    localparam int W    = 8;
    localparam int MAXV = 255;

    logic USER_CLOCK = 1'b0;
    logic RESET      = 1'b1;
    logic MOD_CLK    = 1'b0;
    logic MOD_CLKN   = 1'b0;
    logic MOD_CLKL   = 1'b0;
    logic START      = 1'b0;
    logic RESULT_ACK = 1'b0;
    logic BUSY, RESULT_VALID, PHASE_MISS, TIMEOUT;
    logic [W-1:0] PERIOD, HIGH_CLK, HIGH_CLKN, PHASE, OVERLAP;

    mod_signal_monitor #(.CNT_W(W)) dut (
        .USER_CLOCK  (USER_CLOCK),
        .RESET       (RESET),
        .MOD_CLK     (MOD_CLK),
        .MOD_CLKN    (MOD_CLKN),
        .MOD_CLKL    (MOD_CLKL),
        .START       (START),
        .RESULT_ACK  (RESULT_ACK),
        .BUSY        (BUSY),
        .RESULT_VALID(RESULT_VALID),
        .PERIOD      (PERIOD),
        .HIGH_CLK    (HIGH_CLK),
        .HIGH_CLKN   (HIGH_CLKN),
        .PHASE       (PHASE),
        .OVERLAP     (OVERLAP),
        .PHASE_MISS  (PHASE_MISS),
        .TIMEOUT     (TIMEOUT)
    );

    always #5 USER_CLOCK = ~USER_CLOCK;

    typedef struct {
        int p, h, nlo, nhi, d, hl;
        bit len;
        int e_period, e_hi, e_hin, e_phase, e_ovl;
        bit e_miss, e_to;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Waveform generator state; pins follow phase ph = t mod p of the pattern.
    int g_p = 40, g_h = 20, g_nlo = 20, g_nhi = 40, g_d = 10, g_hl = 20;
    bit g_len   = 1'b1;
    bit g_stuck = 1'b1;
    int g_t     = 0;
    int g_ph    = 0;

    function automatic bit f_clk(input int ph, input int h);
        return ph < h;
    endfunction

    function automatic bit f_clkn(input int ph, input int nlo, input int nhi);
        return (ph >= nlo) && (ph < nhi);
    endfunction

    function automatic bit f_clkl(input int ph, input int p, input int d, input int hl,
                                  input bit len);
        return len && (((ph + p - d) % p) < hl);
    endfunction

    initial begin : gen
        forever begin
            @(negedge USER_CLOCK);
            g_t++;
            g_ph = g_t % g_p;
            if (g_stuck) begin
                MOD_CLK  = 1'b0;
                MOD_CLKN = 1'b0;
                MOD_CLKL = 1'b0;
            end else begin
                MOD_CLK  = f_clk(g_ph, g_h);
                MOD_CLKN = f_clkn(g_ph, g_nlo, g_nhi);
                MOD_CLKL = f_clkl(g_ph, g_p, g_d, g_hl, g_len);
            end
        end
    end

    // One full pin period starting at a CLK rise, truncated at the counter limit.
    function automatic vec_t model(input int p, input int h, input int nlo, input int nhi,
                                   input int d, input int hl, input bit len);
        vec_t v;
        int   n;
        bit   found;
        v.p = p; v.h = h; v.nlo = nlo; v.nhi = nhi; v.d = d; v.hl = hl; v.len = len;
        n = (p >= MAXV) ? MAXV : p;
        v.e_period = n;
        v.e_to     = (p >= MAXV);
        v.e_hi = 0; v.e_hin = 0; v.e_ovl = 0; v.e_phase = MAXV;
        found = 1'b0;
        for (int ph = 0; ph < n; ph++) begin
            v.e_hi  += int'(f_clk(ph, h));
            v.e_hin += int'(f_clkn(ph, nlo, nhi));
            v.e_ovl += int'(f_clk(ph, h) && f_clkn(ph, nlo, nhi));
            if (!found && f_clkl(ph, p, d, hl, len) && !f_clkl((ph + p - 1) % p, p, d, hl, len))
            begin
                found     = 1'b1;
                v.e_phase = ph;
            end
        end
        v.e_miss = !found;
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic apply_pattern(input vec_t v);
        @(negedge USER_CLOCK);
        #1;
        g_p = v.p; g_h = v.h; g_nlo = v.nlo; g_nhi = v.nhi; g_d = v.d; g_hl = v.hl;
        g_len = v.len; g_stuck = 1'b0;
        repeat (v.p + 8) @(negedge USER_CLOCK);
        #1;
    endtask

    // START one cycle before the pin CLK rise so ARM never waits long.
    task automatic start_aligned();
        for (int i = 0; i < g_p + 2 && g_ph != g_p - 1; i++) begin
            @(negedge USER_CLOCK);
            #1;
        end
        START = 1'b1;
        @(negedge USER_CLOCK);
        #1;
        START = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 900 && !got; i++) begin
            @(posedge USER_CLOCK);
            #1;
            got = RESULT_VALID;
        end
        chk({tag, ".valid"}, got, 1);
        chk({tag, ".busy"}, BUSY, 0);
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        chk({tag, ".period"}, PERIOD, v.e_period);
        chk({tag, ".high_clk"}, HIGH_CLK, v.e_hi);
        chk({tag, ".high_clkn"}, HIGH_CLKN, v.e_hin);
        chk({tag, ".phase"}, PHASE, v.e_phase);
        chk({tag, ".overlap"}, OVERLAP, v.e_ovl);
        chk({tag, ".phase_miss"}, PHASE_MISS, v.e_miss);
        chk({tag, ".timeout"}, TIMEOUT, v.e_to);
    endtask

    task automatic ack(input string tag);
        @(negedge USER_CLOCK);
        #1;
        RESULT_ACK = 1'b1;
        @(posedge USER_CLOCK);
        #1;
        chk({tag, ".ack_valid_fall"}, RESULT_VALID, 0);
        @(negedge USER_CLOCK);
        #1;
        RESULT_ACK = 1'b0;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        apply_pattern(v);
        start_aligned();
        wait_valid(tag);
        check_fields(tag, v);
        ack(tag);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl[7];
        vec_t v;
        int   k, bad;
        bit   got;

        //          p    h    nlo  nhi  d    hl  len  per  hi   hin  ph   ovl  miss to
        tbl[0] = '{40,  20,  20,  40,  10,  20, 1,   40,  20,  20,  10,  0,   0,   0};
        tbl[1] = '{40,  20,  18,  40,  10,  20, 1,   40,  20,  22,  10,  2,   0,   0};
        tbl[2] = '{40,  20,  20,  40,  10,  20, 0,   40,  20,  20,  255, 0,   1,   0};
        tbl[3] = '{16,  8,   8,   16,  0,   4,  1,   16,  8,   8,   0,   0,   0,   0};
        tbl[4] = '{10,  3,   0,   10,  9,   1,  1,   10,  3,   10,  9,   3,   0,   0};
        tbl[5] = '{2,   1,   1,   2,   1,   1,  1,   2,   1,   1,   1,   0,   0,   0};
        tbl[6] = '{600, 400, 400, 600, 100, 50, 1,   255, 255, 0,   100, 0,   0,   1};

        repeat (3) @(posedge USER_CLOCK);
        #1;
        chk("reset.busy", BUSY, 0);
        chk("reset.valid", RESULT_VALID, 0);
        chk("reset.period", PERIOD, 0);
        chk("reset.phase", PHASE, 0);
        chk("reset.flags", {PHASE_MISS, TIMEOUT}, 0);
        @(negedge USER_CLOCK);
        #1;
        RESET = 1'b0;

        for (int i = 0; i < 7; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // ARM timeout with CLK stuck low.
        @(negedge USER_CLOCK);
        #1;
        g_stuck = 1'b1;
        repeat (8) @(negedge USER_CLOCK);
        #1;
        START = 1'b1;
        @(posedge USER_CLOCK);
        #1;
        START = 1'b0;
        chk("arm_to.busy", BUSY, 1);
        k = 0;
        got = 1'b0;
        for (int i = 1; i <= 400 && !got; i++) begin
            @(posedge USER_CLOCK);
            #1;
            if (RESULT_VALID) begin
                got = 1'b1;
                k = i;
            end
        end
        chk("arm_to.latency", k, 255);
        chk("arm_to.timeout", TIMEOUT, 1);
        chk("arm_to.fields", {PERIOD, HIGH_CLK, HIGH_CLKN, PHASE, OVERLAP}, 40'hFF_FFFF_FFFF);
        ack("arm_to");

        // RESET in MEAS: outputs drop at once and nothing appears without a new START.
        apply_pattern(tbl[0]);
        start_aligned();
        repeat (15) @(negedge USER_CLOCK);
        #1;
        chk("rst_meas.busy_before", BUSY, 1);
        RESET = 1'b1;
        #1;
        chk("rst_meas.busy", BUSY, 0);
        chk("rst_meas.valid", RESULT_VALID, 0);
        repeat (2) @(negedge USER_CLOCK);
        #1;
        RESET = 1'b0;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge USER_CLOCK);
            #1;
            if (RESULT_VALID || BUSY) bad++;
        end
        chk("rst_meas.no_result", bad, 0);
        start_aligned();
        wait_valid("rst_meas.after");
        check_fields("rst_meas.after", tbl[0]);

        // Results hold in DONE, then START+ACK together re-arms.
        repeat (5) @(posedge USER_CLOCK);
        #1;
        chk("hold.period", PERIOD, 40);
        chk("hold.valid", RESULT_VALID, 1);
        @(negedge USER_CLOCK);
        #1;
        START = 1'b1;
        RESULT_ACK = 1'b1;
        @(posedge USER_CLOCK);
        #1;
        chk("start_ack.valid", RESULT_VALID, 0);
        chk("start_ack.busy", BUSY, 1);
        @(negedge USER_CLOCK);
        #1;
        START = 1'b0;
        RESULT_ACK = 1'b0;
        wait_valid("start_ack");
        check_fields("start_ack", tbl[0]);
        ack("start_ack");

        for (int r = 0; r < 20; r++) begin
            int p, h, nlo, nhi, d, hl;
            bit len;
            p   = $urandom_range(60, 3);
            h   = $urandom_range(p - 1, 1);
            nlo = $urandom_range(p - 1, 0);
            nhi = $urandom_range(p, nlo + 1);
            d   = $urandom_range(p - 1, 0);
            hl  = $urandom_range(p - 1, 1);
            len = ($urandom_range(3, 0) != 0);
            v   = model(p, h, nlo, nhi, d, hl, len);
            run_vec($sformatf("rnd%0d", r), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
